// File: rtl/adc_capture_gate.sv
// adc_capture_gate: arm/trigger gate forwarding NBEATS ADC beats into a small output FIFO.
// Optional threshold trigger: define ADC_CAPTURE_THRESHOLD_TRIGGER_EN.
module adc_capture_gate #(
    parameter int NBEATS          = 1024,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic         aclk,
    input  logic         aclk_rst,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    input  logic         arm_i,
    input  logic         trig_i,
    input  logic [15:0]  threshold_i,
    output logic         armed_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         overflow_o,
    output logic [15:0]  beat_count_o
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [15:0] LAST = 16'(NBEATS);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FLUSH, DONE} state_t;
    state_t state, state_n;

    logic [127:0] in_data;
    logic         in_valid, in_trig, pend, hit, armed, clr, take;
    logic [127:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  fill;
    logic         full, empty, push, pop;
    logic [15:0]  count_n;

`ifdef ADC_CAPTURE_THRESHOLD_TRIGGER_EN
    logic [7:0] over;
    for (genvar i = 0; i < 8; i++) begin : g_mag
        logic [15:0] s, mag;
        assign s = s_axis_tdata[16*i +: 16];
        assign mag = s[15] ? ((s == 16'h8000) ? 16'h7fff : -s) : s;
        assign over[i] = mag >= threshold_i;
    end
    assign hit = |over;
`else
    logic unused_thr;
    assign unused_thr = ^threshold_i;
    assign hit = 1'b0;
`endif

    assign armed = state == ARMED;
    assign s_axis_tready = 1'b1;

    // A trigger only counts while armed; a beatless trigger waits for the next beat.
    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            in_data  <= '0;
            in_valid <= 1'b0;
            in_trig  <= 1'b0;
            pend     <= 1'b0;
        end else begin
            in_data  <= s_axis_tdata;
            in_valid <= s_axis_tvalid;
            in_trig  <= s_axis_tvalid & (pend | (armed & (trig_i | hit)));
            pend     <= armed & ~s_axis_tvalid & (pend | trig_i);
        end
    end

    assign take    = in_valid & ((state == CAPTURE) | (armed & in_trig));
    assign full    = fill == (AW+1)'(DEPTH);
    assign empty   = fill == '0;
    assign push    = take & ~full;
    assign pop     = ~empty & m_axis_tready;
    assign count_n = beat_count_o + 16'd1;

    always_comb begin
        clr     = arm_i & ((state == IDLE) | (state == FLUSH) | (state == DONE));
        state_n = state;
        if (clr)
            state_n = ARMED;
        else if (take)
            state_n = (count_n == LAST) ? FLUSH : CAPTURE;
        else if ((state == FLUSH) && empty)
            state_n = DONE;
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state        <= IDLE;
            beat_count_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            state <= state_n;
            if (clr) begin
                beat_count_o <= '0;
                overflow_o   <= 1'b0;
            end else if (take) begin
                beat_count_o <= count_n;
                overflow_o   <= overflow_o | full;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fill   <= fill + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? '0 : mem[rd_ptr];
    assign armed_o       = armed;
    assign busy_o        = (state == CAPTURE) | (state == FLUSH);
    assign done_o        = state == DONE;
endmodule

// File: tb/tb_adc_capture_gate.sv
// tb_adc_capture_gate: table-driven, directed and randomized checks of adc_capture_gate
// against a queue-based capture model.
module tb_adc_capture_gate;
    localparam int NB = 1024;
    localparam int DEPTH = 16;
`ifdef ADC_CAPTURE_THRESHOLD_TRIGGER_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, s_tvalid = 1'b0, m_tready = 1'b1, arm = 1'b0, trig = 1'b0;
    logic [127:0] s_tdata = '0;
    logic [15:0]  thr = 16'hffff;
    logic         s_tready, m_tvalid, armed, busy, done, ovf;
    logic         s_tready1, m_tvalid1, armed1, busy1, done1, ovf1;
    logic [127:0] m_tdata, m_tdata1;
    logic [15:0]  cnt, cnt1;

    adc_capture_gate #(.NBEATS(NB), .FIFO_DEPTH_LOG2(4)) dut (
        .aclk(clk), .aclk_rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .arm_i(arm), .trig_i(trig), .threshold_i(thr),
        .armed_o(armed), .busy_o(busy), .done_o(done), .overflow_o(ovf), .beat_count_o(cnt));

    adc_capture_gate #(.NBEATS(1), .FIFO_DEPTH_LOG2(4)) dut1 (
        .aclk(clk), .aclk_rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready1), .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1),
        .m_axis_tready(m_tready), .arm_i(arm), .trig_i(trig), .threshold_i(thr),
        .armed_o(armed1), .busy_o(busy1), .done_o(done1), .overflow_o(ovf1), .beat_count_o(cnt1));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a capture window of NB valid beats tagged at input time, then a bounded FIFO queue.
    logic [127:0] q[$], got[$];
    bit           m_armed, m_pend, m_ovf, p_v, p_w;
    logic [127:0] p_d;
    int           m_left, m_cnt, m_drops, nb;

    function automatic logic [127:0] mk(input int n);
        logic [15:0] v;
        v = 16'(n);
        return {96'b0, 8'b0, v[15:8], 8'b0, v[7:0]};
    endfunction

    function automatic bit thr_hit(input logic [127:0] d, input logic [15:0] t);
        bit h = 0;
        for (int i = 0; i < 8; i++) begin
            int s, m;
            s = int'($signed(d[16*i +: 16]));
            m = (s < 0) ? -s : s;
            if (m > 32767) m = 32767;
            if (m >= int'(t)) h = 1;
        end
        return THR_EN && h;
    endfunction

    task automatic cyc();
        bit full, w, busy_m;
        chk("tvalid", m_tvalid, q.size() > 0);
        if (q.size() > 0) chk("tdata", m_tdata, q[0]);
        chk("count", cnt, m_cnt);
        chk("overflow", ovf, m_ovf);
        if (rst) begin
            q.delete();
            {m_armed, m_pend, m_ovf, p_v, p_w} = '0;
            m_left = 0;
            m_cnt = 0;
        end else begin
            full = q.size() == DEPTH;
            if (q.size() > 0 && m_tready) got.push_back(q.pop_front());
            if (p_v && p_w) begin
                m_cnt++;
                if (full) begin
                    m_ovf = 1;
                    m_drops++;
                end else q.push_back(p_d);
            end
            busy_m = m_left > 0 || (p_v && p_w);
            w = 0;
            if (s_tvalid && m_left > 0) begin
                w = 1;
                m_left--;
            end else if (s_tvalid && m_armed && (m_pend || trig || thr_hit(s_tdata, thr))) begin
                w = 1;
                m_left = NB - 1;
                m_armed = 0;
                m_pend = 0;
            end else if (m_armed && trig) m_pend = 1;
            if (arm && !m_armed && !busy_m && !w) begin
                m_armed = 1;
                m_cnt = 0;
                m_ovf = 0;
            end
            p_v = s_tvalid;
            p_w = w;
            p_d = s_tdata;
        end
        @(negedge clk);
    endtask

    task automatic tick(input bit v, input bit a = 0, input bit t = 0, input bit xe = 0,
                        input logic [15:0] x = 16'h0);
        s_tvalid = v;
        arm = a;
        trig = t;
        s_tdata = v ? mk(nb) : '0;
        if (xe) s_tdata[127:112] = x;
        cyc();
        if (v) nb++;
        arm = 0;
        trig = 0;
    endtask

    task automatic reset_cycle();
        rst = 1;
        tick(0);
        rst = 0;
    endtask

    task automatic run_done(input int budget, input int pv, input int pr, input bit rarm);
        int k = 0;
        while (!done && k < budget) begin
            m_tready = $urandom_range(99) < pr;
            tick($urandom_range(99) < pv, rarm && busy && cnt < 1000 && $urandom_range(15) == 0,
                 $urandom_range(31) == 0);
            k++;
        end
        m_tready = 1;
        chk("done_reached", done, 1);
    endtask

    typedef struct {
        bit r, a, t, v;
        bit ea, eb, ed, ev;
        int ec, en;
    } row_t;
    row_t tab[15];

    initial begin
        int tb;
        logic [127:0] xd;
        tab[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, -1};
        tab[1]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, -1};
        tab[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, -1};
        tab[3]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, -1};
        tab[4]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, -1};
        tab[5]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, -1};
        tab[6]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, -1};
        tab[7]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 4};
        tab[8]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, -1};
        tab[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, -1};
        tab[10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, -1};
        tab[11] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, -1};
        tab[12] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 6};
        tab[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, -1};
        tab[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, -1};
        repeat (2) @(negedge clk);
        nb = 0;
        for (int i = 0; i < 15; i++) begin
            rst = tab[i].r;
            tick(tab[i].v, tab[i].a, tab[i].t);
            rst = 0;
            chk($sformatf("n1_armed[%0d]", i), armed1, tab[i].ea);
            chk($sformatf("n1_busy[%0d]", i), busy1, tab[i].eb);
            chk($sformatf("n1_done[%0d]", i), done1, tab[i].ed);
            chk($sformatf("n1_tvalid[%0d]", i), m_tvalid1, tab[i].ev);
            chk($sformatf("n1_count[%0d]", i), cnt1, 16'(tab[i].ec));
            if (tab[i].en >= 0) chk($sformatf("n1_tdata[%0d]", i), m_tdata1, mk(tab[i].en));
        end

        reset_cycle();
        tick(1, 1, 0);
        tick(1);
        got.delete();
        tb = nb;
        tick(1, 0, 1);
        run_done(3000, 100, 100, 0);
        chk("ramp_beats", got.size(), NB);
        if (got.size() > 0) chk("ramp_first", got[0], mk(tb));
        if (got.size() == NB) chk("ramp_last", got[NB-1], mk(tb + NB - 1));
        chk("ramp_ovf", ovf, 0);

        reset_cycle();
        tick(1, 1, 0);
        got.delete();
        m_drops = 0;
        tb = nb;
        tick(1, 0, 1);
        repeat (500) tick(1);
        m_tready = 0;
        repeat (40) tick(1);
        m_tready = 1;
        run_done(3000, 100, 100, 0);
        chk("bp_ovf", ovf, 1);
        chk("bp_count", cnt, NB);
        chk("bp_beats", got.size(), NB - m_drops);
        if (got.size() > 0) chk("bp_first", got[0], mk(tb));

        for (int r = 0; r < 2; r++) begin
            reset_cycle();
            repeat ($urandom_range(5)) tick($urandom_range(1));
            tick($urandom_range(1), 1, 0);
            repeat ($urandom_range(20)) tick($urandom_range(99) < 70);
            tick($urandom_range(1), 0, 1);
            run_done(8000, 70, 60, 1);
            chk("rnd_count", cnt, NB);
        end

        reset_cycle();
        tick(1, 1, 0);
        tick(1, 0, 1);
        for (int k = 0; k < 1000 && cnt != 300; k++) tick(1);
        chk("abort_at_300", cnt, 300);
        rst = 1;
        tick(1);
        rst = 0;
        chk("abort_tvalid", m_tvalid, 0);
        chk("abort_status", {armed, busy, done, ovf, cnt}, 20'h0);
        got.delete();
        repeat (30) tick(1);
        chk("abort_quiet", got.size(), 0);
        tick(1, 1, 0);
        tick(1, 0, 1);
        run_done(3000, 100, 100, 0);
        chk("rearm_beats", got.size(), NB);

`ifdef ADC_CAPTURE_THRESHOLD_TRIGGER_EN
        reset_cycle();
        thr = 16'd1000;
        tick(1, 1, 0);
        got.delete();
        repeat (57) tick(1);
        xd = mk(nb);
        xd[127:112] = 16'hfc18;
        tick(1, 0, 0, 1, 16'hfc18);
        repeat (10) tick(1);
        chk("thr_1000_busy", busy, 1);
        if (got.size() > 0) chk("thr_1000_first", got[0], xd);
        else chk("thr_1000_first", 0, xd);
        reset_cycle();
        tick(1, 1, 0);
        got.delete();
        tick(1, 0, 0, 1, 16'hfc19);
        repeat (10) tick(1);
        chk("thr_999_armed", armed, 1);
        chk("thr_999_out", got.size(), 0);
        reset_cycle();
        thr = 16'd32767;
        tick(1, 1, 0);
        tick(1, 0, 0, 1, 16'h8000);
        repeat (5) tick(1);
        chk("thr_min_busy", busy, 1);
        reset_cycle();
        thr = 16'hffff;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
